instr_fetch: RTL

- Fetch stage directly upstream of the instruction decoder (`control`).
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles PC redirects (branch/jump) by flushing the buffer and discarding stale in-flight responses.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instr_fetch.sv | 91 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants, opcodes and fetch buffer entry type
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous {pc, instr} FIFO with flush, count and full/empty flags
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push into a full FIFO is fine then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, credit-limited imem requests, response buffer to decode
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, last_pc_q, redirect_target;
  logic [CW-1:0]   in_flight_q, in_flight_d, drop_cnt_q, drop_cnt_d, fifo_count;
  logic [CW:0]     occupancy;
  logic            req_fire, rsp_fire, push, pop, fifo_full, fifo_empty;
  logic            unused_full;
  fetch_entry_t    push_entry, head_entry;

  // Credits: every outstanding request owns a FIFO slot, so the buffer can never overflow.
  assign occupancy      = {1'b0, in_flight_q} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (in_flight_q != '0);

  assign redirect_target = word_align(redirect_pc);
  assign push            = rsp_fire && !redirect_valid && (drop_cnt_q == '0);
  assign push_entry      = '{pc: rsp_pc_q, instr: imem_rsp_data};
  assign pop             = instr_valid && instr_ready;
  assign unused_full     = fifo_full;

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? NOP_INSTR : head_entry.instr;
  assign instr_pc    = fifo_empty ? last_pc_q : head_entry.pc;

  always_comb begin
    in_flight_d = in_flight_q + CW'(req_fire) - CW'(rsp_fire);
    pc_d        = req_fire ? pc_plus4(pc_q) : pc_q;
    rsp_pc_d    = push ? pc_plus4(rsp_pc_q) : rsp_pc_q;
    drop_cnt_d  = drop_cnt_q;
    if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    // Everything still outstanding after this edge belongs to the old stream.
    if (redirect_valid) begin
      pc_d       = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_cnt_d = in_flight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
      last_pc_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
      last_pc_q   <= instr_pc;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
